// File: rtl/alu_result_writer_pkg.sv
// Shared constants and FSM state type for the ALU result writer.
// DATA_W / ADDR_W are the defaults for the result word and RAM address
// widths; GROUP_SIZE words form one group, FIFO_DEPTH groups may be buffered.
package alu_result_pkg;

    localparam int unsigned DATA_W     = 18;
    localparam int unsigned ADDR_W     = 4;
    localparam int unsigned GROUP_SIZE = 4;
    localparam int unsigned FIFO_DEPTH = 2;

    // Encodings kept identical to the legacy localparam values.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } wr_state_e;

endpackage

// File: rtl/alu_result_writer_if.sv
// Result RAM write port.
//   ram_we    : write request (master -> slave)
//   ram_addr  : write address (master -> slave)
//   ram_wdata : write data    (master -> slave)
//   ram_ready : RAM accepts the write this cycle (slave -> master)
interface alu_result_writer_if #(
    parameter int unsigned DATA_W = alu_result_pkg::DATA_W,
    parameter int unsigned ADDR_W = alu_result_pkg::ADDR_W
);

    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_ready;

    modport master (
        output ram_we,
        output ram_addr,
        output ram_wdata,
        input  ram_ready
    );

    modport slave (
        input  ram_we,
        input  ram_addr,
        input  ram_wdata,
        output ram_ready
    );

endinterface

// File: rtl/alu_result_writer_fifo.sv
// result_group_fifo: two-entry FIFO of result groups {last, 4 x DATA_W}.
// Slot 0 is always the head; a pop shifts slot 1 down. A push in the same
// cycle as a pop may use the slot the pop frees, so a full FIFO still
// accepts a group when its head leaves that cycle.
//   clk, rst   : clock, asynchronous active-low reset
//   push       : store push_data/push_last (ignored when full without pop)
//   pop        : discard the head group
//   head_data  : head group words, element 0 = first word written
//   head_last  : head group is the final group of a matrix
//   full/empty : occupancy status
module result_group_fifo #(
    parameter int unsigned DATA_W = 18
) (
    input  logic                                               clk,
    input  logic                                               rst,
    input  logic                                               push,
    input  logic                                               push_last,
    input  logic [alu_result_pkg::GROUP_SIZE-1:0][DATA_W-1:0]  push_data,
    input  logic                                               pop,
    output logic [alu_result_pkg::GROUP_SIZE-1:0][DATA_W-1:0]  head_data,
    output logic                                               head_last,
    output logic                                               full,
    output logic                                               empty
);

    import alu_result_pkg::*;

    localparam logic [1:0] DEPTH = 2'(FIFO_DEPTH);

    typedef logic [GROUP_SIZE-1:0][DATA_W-1:0] group_t;

    group_t     slot_data [FIFO_DEPTH];
    logic       slot_last [FIFO_DEPTH];
    logic [1:0] count;
    logic       pop_ok;
    logic       push_ok;

    assign empty     = (count == 2'd0);
    assign full      = (count == DEPTH);
    assign pop_ok    = pop && !empty;
    assign push_ok   = push && (!full || pop_ok);
    assign head_data = slot_data[0];
    assign head_last = slot_last[0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count        <= '0;
            slot_data[0] <= '0;
            slot_data[1] <= '0;
            slot_last[0] <= 1'b0;
            slot_last[1] <= 1'b0;
        end else begin
            if (pop_ok) begin
                slot_data[0] <= slot_data[1];
                slot_last[0] <= slot_last[1];
                slot_data[1] <= '0;
                slot_last[1] <= 1'b0;
            end
            // The write position is the occupancy after the pop; the later
            // assignment overrides the pop's clearing of slot 1.
            if (push_ok) begin
                if (count == 2'd0 || (pop_ok && count == 2'd1)) begin
                    slot_data[0] <= push_data;
                    slot_last[0] <= push_last;
                end else begin
                    slot_data[1] <= push_data;
                    slot_last[1] <= push_last;
                end
            end
            count <= count + {1'b0, push_ok} - {1'b0, pop_ok};
        end
    end

endmodule

// File: rtl/alu_result_writer.sv
// alu_result_writer: consumer end of the ALU result interface.
// Captures MU1..MU4 one cycle after four_results_ready (the MU values
// settle on the edge that ends the flag cycle), buffers up to two groups
// and writes them one word per accepted cycle to the result RAM at
// address 4g+k. done pulses after the group flagged by all_results_ready
// has been fully written; the address counter then restarts at 0.
//   clk, rst            : clock, asynchronous active-low reset
//   MU1..MU4            : ALU accumulator outputs
//   four_results_ready  : ALU group-complete flag
//   all_results_ready   : ALU last-group flag (qualified by four_results_ready)
//   ram                 : RAM write port (master side)
//   busy                : a group is buffered or the FSM is not idle
//   done                : one-cycle pulse after the final group is written
//   overflow            : sticky, a group was dropped because both slots were full
module alu_result_writer #(
    parameter int unsigned DATA_W = alu_result_pkg::DATA_W,
    parameter int unsigned ADDR_W = alu_result_pkg::ADDR_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_W-1:0]          MU1,
    input  logic [DATA_W-1:0]          MU2,
    input  logic [DATA_W-1:0]          MU3,
    input  logic [DATA_W-1:0]          MU4,
    input  logic                       four_results_ready,
    input  logic                       all_results_ready,
    alu_result_writer_if.master        ram,
    output logic                       busy,
    output logic                       done,
    output logic                       overflow
);

    import alu_result_pkg::*;

    typedef logic [GROUP_SIZE-1:0][DATA_W-1:0] group_t;

    wr_state_e         state_q;
    logic [1:0]        k_q;
    logic [ADDR_W-1:0] addr_q;
    logic              cap_pend;
    logic              last_pend;
    logic              overflow_q;

    group_t            head_data;
    logic              head_last;
    logic              fifo_full;
    logic              fifo_empty;
    logic              accept;
    logic              pop;

    assign accept = (state_q == ST_WRITE) && ram.ram_ready;
    assign pop    = accept && (k_q == 2'd3);

    result_group_fifo #(
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (cap_pend),
        .push_last (last_pend),
        .push_data ({MU4, MU3, MU2, MU1}),
        .pop       (pop),
        .head_data (head_data),
        .head_last (head_last),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Flag capture and sticky overflow. A capture into a full FIFO is only
    // lost when the head is not leaving in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap_pend   <= 1'b0;
            last_pend  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            cap_pend  <= four_results_ready;
            last_pend <= four_results_ready && all_results_ready;
            if (cap_pend && fifo_full && !pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Write sequencer: element index, address counter and state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            addr_q  <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        state_q <= ST_WRITE;
                        k_q     <= '0;
                    end
                end
                ST_WRITE: begin
                    if (accept) begin
                        addr_q <= addr_q + ADDR_W'(1);
                        k_q    <= k_q + 2'd1;
                        if (k_q == 2'd3) begin
                            k_q <= '0;
                            // After the pop the FIFO still holds a group if it
                            // was full or a capture lands this same cycle.
                            if (head_last) begin
                                state_q <= ST_DONE;
                            end else if (fifo_full || cap_pend) begin
                                state_q <= ST_WRITE;
                            end else begin
                                state_q <= ST_IDLE;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    addr_q <= '0;
                    if (!fifo_empty) begin
                        state_q <= ST_WRITE;
                        k_q     <= '0;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs decode registered state only.
    assign ram.ram_we    = (state_q == ST_WRITE);
    assign ram.ram_addr  = addr_q;
    assign ram.ram_wdata = (state_q == ST_WRITE) ? head_data[k_q] : '0;
    assign done          = (state_q == ST_DONE);
    assign busy          = !fifo_empty || (state_q != ST_IDLE);
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_alu_result_writer.sv
module tb_alu_result_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic [17:0] mu1, mu2, mu3, mu4;
    logic        four_rdy;
    logic        all_rdy;
    logic        busy, done, overflow;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int          log_cyc  [$];
    logic [3:0]  log_addr [$];
    logic [17:0] log_data [$];
    int          done_cyc [$];

    alu_result_writer_if #(.DATA_W(18), .ADDR_W(4)) ram_bus ();

    alu_result_writer #(.DATA_W(18), .ADDR_W(4)) dut (
        .clk                (clk),
        .rst                (rst),
        .MU1                (mu1),
        .MU2                (mu2),
        .MU3                (mu3),
        .MU4                (mu4),
        .four_results_ready (four_rdy),
        .all_results_ready  (all_rdy),
        .ram                (ram_bus),
        .busy               (busy),
        .done               (done),
        .overflow           (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            if (ram_bus.ram_we && ram_bus.ram_ready) begin
                log_cyc.push_back(cyc);
                log_addr.push_back(ram_bus.ram_addr);
                log_data.push_back(ram_bus.ram_wdata);
            end
            if (done) done_cyc.push_back(cyc);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) step();
    endtask

    task automatic clear_log();
        log_cyc.delete();
        log_addr.delete();
        log_data.delete();
        done_cyc.delete();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        four_rdy = 1'b0;
        all_rdy = 1'b0;
        ram_bus.ram_ready = 1'b1;
        mu1 = '0; mu2 = '0; mu3 = '0; mu4 = '0;
        step();
        step();
        rst = 1'b1;
        clear_log();
        step();
    endtask

    // Flag in cycle t, MU values in cycle t+1; returns in cycle t+2.
    task automatic send_group(input logic [17:0] base, input logic last, output int t);
        t = cyc;
        four_rdy = 1'b1;
        all_rdy = last;
        step();
        four_rdy = 1'b0;
        all_rdy = 1'b0;
        mu1 = base;
        mu2 = base + 18'd1;
        mu3 = base + 18'd2;
        mu4 = base + 18'd3;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        four_rdy = 1'b0;
        all_rdy = 1'b0;
        ram_bus.ram_ready = 1'b1;
        mu1 = 18'd7; mu2 = 18'd7; mu3 = 18'd7; mu4 = 18'd7;
        wait_cycles(3);
        @(negedge clk);
        total++; if (ram_bus.ram_we !== 1'b0) begin bad++; $display("FAIL reset_we: got %b want 0", ram_bus.ram_we); end
        total++; if (ram_bus.ram_addr !== 4'd0) begin bad++; $display("FAIL reset_addr: got %0d want 0", ram_bus.ram_addr); end
        total++; if (ram_bus.ram_wdata !== 18'd0) begin bad++; $display("FAIL reset_wdata: got %0d want 0", ram_bus.ram_wdata); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        step();
    endtask

    task automatic test_single_group();
        int t;
        do_reset();
        send_group(18'd1, 1'b0, t);
        wait_cycles(8);
        total++;
        if (log_data.size() !== 4) begin
            bad++; $display("FAIL single_count: got %0d want 4", log_data.size());
        end
        for (int i = 0; i < log_data.size() && i < 4; i++) begin
            total++;
            if (log_addr[i] !== 4'(i) || log_data[i] !== 18'(i + 1) || log_cyc[i] !== t + 3 + i) begin
                bad++;
                $display("FAIL single_word%0d: addr=%0d data=%0d cyc=%0d want addr=%0d data=%0d cyc=%0d",
                         i, log_addr[i], log_data[i], log_cyc[i], i, i + 1, t + 3 + i);
            end
        end
        total++;
        if (done_cyc.size() !== 0) begin
            bad++; $display("FAIL single_done: got %0d pulses want 0", done_cyc.size());
        end
    endtask

    task automatic test_full_matrix();
        int t;
        int t0;
        int t_last;
        int exp_c;
        do_reset();
        t0 = 0;
        for (int g = 0; g < 4; g++) begin
            send_group(18'(100 + 4 * g), (g == 3), t);
            if (g == 0) t0 = t;
            if (g < 3) wait_cycles(6);
        end
        t_last = t;
        wait_cycles(10);
        total++;
        if (log_data.size() !== 16) begin
            bad++; $display("FAIL matrix_count: got %0d want 16", log_data.size());
        end
        for (int i = 0; i < log_data.size() && i < 16; i++) begin
            exp_c = t0 + 8 * (i / 4) + 3 + (i % 4);
            total++;
            if (log_addr[i] !== 4'(i) || log_data[i] !== 18'(100 + i) || log_cyc[i] !== exp_c) begin
                bad++;
                $display("FAIL matrix_word%0d: addr=%0d data=%0d cyc=%0d want addr=%0d data=%0d cyc=%0d",
                         i, log_addr[i], log_data[i], log_cyc[i], i, 100 + i, exp_c);
            end
        end
        total++;
        if (done_cyc.size() !== 1) begin
            bad++; $display("FAIL matrix_done_count: got %0d want 1", done_cyc.size());
        end else begin
            total++;
            if (done_cyc[0] !== t_last + 7) begin
                bad++; $display("FAIL matrix_done_cycle: got %0d want %0d", done_cyc[0], t_last + 7);
            end
        end
        @(negedge clk);
        total++; if (ram_bus.ram_addr !== 4'd0) begin bad++; $display("FAIL matrix_addr_after: got %0d want 0", ram_bus.ram_addr); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL matrix_busy_after: got %b want 0", busy); end
    endtask

    task automatic test_back_pressure();
        int t;
        int exp_c[4];
        do_reset();
        send_group(18'd10, 1'b0, t);
        wait_cycles(3);
        ram_bus.ram_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            total++;
            if (ram_bus.ram_we !== 1'b1 || ram_bus.ram_addr !== 4'd2 || ram_bus.ram_wdata !== 18'd12) begin
                bad++;
                $display("FAIL stall_hold%0d: we=%b addr=%0d data=%0d want we=1 addr=2 data=12",
                         s, ram_bus.ram_we, ram_bus.ram_addr, ram_bus.ram_wdata);
            end
            step();
        end
        ram_bus.ram_ready = 1'b1;
        wait_cycles(6);
        exp_c[0] = t + 3; exp_c[1] = t + 4; exp_c[2] = t + 8; exp_c[3] = t + 9;
        total++;
        if (log_data.size() !== 4) begin
            bad++; $display("FAIL stall_count: got %0d want 4", log_data.size());
        end
        for (int i = 0; i < log_data.size() && i < 4; i++) begin
            total++;
            if (log_addr[i] !== 4'(i) || log_data[i] !== 18'(10 + i) || log_cyc[i] !== exp_c[i]) begin
                bad++;
                $display("FAIL stall_word%0d: addr=%0d data=%0d cyc=%0d want addr=%0d data=%0d cyc=%0d",
                         i, log_addr[i], log_data[i], log_cyc[i], i, 10 + i, exp_c[i]);
            end
        end
    endtask

    task automatic test_overflow();
        int t;
        int exp_d;
        do_reset();
        ram_bus.ram_ready = 1'b0;
        send_group(18'd200, 1'b0, t);
        send_group(18'd210, 1'b0, t);
        @(negedge clk);
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_before_third: got %b want 0", overflow); end
        step();
        send_group(18'd220, 1'b0, t);
        @(negedge clk);
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_after_third: got %b want 1", overflow); end
        wait_cycles(24);
        @(negedge clk);
        total++;
        if (log_data.size() !== 0 || ram_bus.ram_we !== 1'b1) begin
            bad++; $display("FAIL ovf_stalled: writes=%0d we=%b want writes=0 we=1", log_data.size(), ram_bus.ram_we);
        end
        step();
        ram_bus.ram_ready = 1'b1;
        wait_cycles(20);
        total++;
        if (log_data.size() !== 8) begin
            bad++; $display("FAIL ovf_count: got %0d want 8", log_data.size());
        end
        for (int i = 0; i < log_data.size() && i < 8; i++) begin
            exp_d = (i < 4) ? 200 + i : 206 + i;
            total++;
            if (log_addr[i] !== 4'(i) || log_data[i] !== 18'(exp_d)) begin
                bad++;
                $display("FAIL ovf_word%0d: addr=%0d data=%0d want addr=%0d data=%0d",
                         i, log_addr[i], log_data[i], i, exp_d);
            end
        end
        @(negedge clk);
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ovf_busy_after: got %b want 0", busy); end
    endtask

    task automatic test_pop_push();
        int t;
        int exp_d;
        do_reset();
        ram_bus.ram_ready = 1'b0;
        send_group(18'd300, 1'b0, t);
        send_group(18'd310, 1'b0, t);
        ram_bus.ram_ready = 1'b1;
        step();
        step();
        four_rdy = 1'b1;
        step();
        four_rdy = 1'b0;
        mu1 = 18'd320; mu2 = 18'd321; mu3 = 18'd322; mu4 = 18'd323;
        @(negedge clk);
        total++;
        if (ram_bus.ram_we !== 1'b1 || ram_bus.ram_addr !== 4'd3 || ram_bus.ram_wdata !== 18'd303) begin
            bad++;
            $display("FAIL poppush_align: we=%b addr=%0d data=%0d want we=1 addr=3 data=303",
                     ram_bus.ram_we, ram_bus.ram_addr, ram_bus.ram_wdata);
        end
        step();
        wait_cycles(20);
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL popush_overflow: got %b want 0", overflow); end
        total++;
        if (log_data.size() !== 12) begin
            bad++; $display("FAIL popush_count: got %0d want 12", log_data.size());
        end
        for (int i = 0; i < log_data.size() && i < 12; i++) begin
            exp_d = 300 + 10 * (i / 4) + (i % 4);
            total++;
            if (log_addr[i] !== 4'(i) || log_data[i] !== 18'(exp_d)) begin
                bad++;
                $display("FAIL popush_word%0d: addr=%0d data=%0d want addr=%0d data=%0d",
                         i, log_addr[i], log_data[i], i, exp_d);
            end
        end
    endtask

    task automatic test_reset_mid_write();
        int t;
        do_reset();
        send_group(18'd400, 1'b0, t);
        wait_cycles(3);
        @(negedge clk);
        total++;
        if (ram_bus.ram_addr !== 4'd2 || ram_bus.ram_wdata !== 18'd402) begin
            bad++; $display("FAIL midrst_pre: addr=%0d data=%0d want addr=2 data=402", ram_bus.ram_addr, ram_bus.ram_wdata);
        end
        #2;
        rst = 1'b0;
        #1;
        total++;
        if (ram_bus.ram_we !== 1'b0 || ram_bus.ram_addr !== 4'd0 || ram_bus.ram_wdata !== 18'd0) begin
            bad++;
            $display("FAIL midrst_ram: we=%b addr=%0d data=%0d want 0 0 0",
                     ram_bus.ram_we, ram_bus.ram_addr, ram_bus.ram_wdata);
        end
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || overflow !== 1'b0) begin
            bad++; $display("FAIL midrst_status: busy=%b done=%b overflow=%b want 0 0 0", busy, done, overflow);
        end
        step();
        rst = 1'b1;
        clear_log();
        step();
        send_group(18'd500, 1'b0, t);
        wait_cycles(8);
        total++;
        if (log_data.size() !== 4) begin
            bad++; $display("FAIL midrst_count: got %0d want 4", log_data.size());
        end
        for (int i = 0; i < log_data.size() && i < 4; i++) begin
            total++;
            if (log_addr[i] !== 4'(i) || log_data[i] !== 18'(500 + i)) begin
                bad++;
                $display("FAIL midrst_word%0d: addr=%0d data=%0d want addr=%0d data=%0d",
                         i, log_addr[i], log_data[i], i, 500 + i);
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        four_rdy = 1'b0;
        all_rdy = 1'b0;
        ram_bus.ram_ready = 1'b1;
        mu1 = '0; mu2 = '0; mu3 = '0; mu4 = '0;
        test_reset();
        test_single_group();
        test_full_matrix();
        test_back_pressure();
        test_overflow();
        test_pop_push();
        test_reset_mid_write();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
